sum_n_k_lanes: RTL and testbench

- Parametrised, handshake-driven multi-operand adder. Sums N operands of W bits using LANES time-multiplexed adders.
- Operation has three parts:
  - Accumulation: one operand group per lane per cycle.
  - Reduction: a pairwise lane-reduction tree.
  - Completion: a registered result with a done pulse.
- Successor to the fixed 30-operand, 5-adder summer. It adds:
  - generic N, W and LANES;
  - a start/busy/done handshake;
  - operand capture;
  - a signed mode.

---
 rtl/sum_n_k_lanes.sv | 127 ++++++++++++
 tb/tb_sum_n_k_lanes.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sum_n_k_lanes.sv
// Multi-operand adder: N operands of W bits summed by LANES time-multiplexed
// accumulators, then folded by a pairwise reduction tree into a registered sum.
module sum_n_k_lanes #(
  parameter int N      = 30,
  parameter int W      = 5,
  parameter int LANES  = 5,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*W-1:0]    nums,
  output logic              busy,
  output logic              done,
  output logic [W+$clog2(N)-1:0] sum
);

  localparam int OW = W + $clog2(N);
  localparam int C1 = (N + LANES - 1) / LANES;
  localparam int R  = $clog2(LANES);
  localparam int L  = C1 + R;
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] step;
  logic          last_step;
  logic [W-1:0]  op_buf  [N];
  logic [OW-1:0] acc     [LANES];
  logic [OW-1:0] acc_nxt [LANES];
  logic [OW-1:0] ops     [C1*LANES];

  function automatic logic [OW-1:0] ext(input logic [W-1:0] v);
    if (SIGNED != 0) return {{(OW-W){v[W-1]}}, v};
    return {{(OW-W){1'b0}}, v};
  endfunction

  assign busy = (state != IDLE);

  // Operand table padded to a whole number of lane groups; pad slots add 0.
  always_comb begin
    for (int i = 0; i < C1*LANES; i++) ops[i] = '0;
    for (int i = 0; i < N; i++) ops[i] = ext(op_buf[i]);
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    last_step = 1'b0;
    acc_nxt   = acc;
    case (state)
      IDLE: if (start) state_nxt = ACCUM;
      ACCUM: begin
        for (int j = 0; j < LANES; j++) begin
          logic [OW-1:0] lane_op;
          lane_op = '0;
          for (int k = 0; k < C1; k++)
            if (step == CW'(k)) lane_op = ops[k*LANES + j];
          acc_nxt[j] = acc[j] + lane_op;
        end
        if (step == CW'(C1 - 1)) begin
          if (R == 0) begin
            state_nxt = IDLE;
            last_step = 1'b1;
          end else begin
            state_nxt = REDUCE;
          end
        end
      end
      REDUCE: begin
        // Folding every pair each step is equivalent to folding only the
        // active ones: slots above the live half are zeroed and add nothing.
        for (int i = 0; i < LANES; i++) acc_nxt[i] = '0;
        for (int i = 0; i < LANES / 2; i++) acc_nxt[i] = acc[2*i] + acc[2*i + 1];
        if (LANES % 2 == 1) acc_nxt[LANES / 2] = acc[LANES - 1];
        if (step == CW'(R - 1)) begin
          state_nxt = IDLE;
          last_step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the operand buffer and accumulators are reset explicitly; an
  // abandoned operation must leave no stale operands or partial sums behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= '0;
      done <= 1'b0;
      sum  <= '0;
      for (int i = 0; i < N; i++)     op_buf[i] <= '0;
      for (int j = 0; j < LANES; j++) acc[j]    <= '0;
    end else begin
      done <= last_step;
      if (last_step) sum <= acc_nxt[0];
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++)     op_buf[i] <= nums[i*W +: W];
            for (int j = 0; j < LANES; j++) acc[j]    <= '0;
            step <= '0;
          end
        end
        ACCUM: begin
          acc  <= acc_nxt;
          step <= (step == CW'(C1 - 1)) ? '0 : step + CW'(1);
        end
        REDUCE: begin
          acc  <= acc_nxt;
          step <= step + CW'(1);
        end
        default: step <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_n_k_lanes.sv
// Randomised self-checking bench: five sum_n_k_lanes instances (lane sweep and
// signed mode) compared against a plain-arithmetic sum and latency formula.
module tb_sum_n_k_lanes;

  localparam int N  = 30;
  localparam int W  = 5;
  localparam int OW = 10;
  localparam int ND = 5;

  localparam int LANES_OF [ND] = '{5, 1, 8, 30, 5};
  localparam bit SGN_OF   [ND] = '{0, 0, 0, 0, 1};

  logic           clk = 1'b0;
  logic           rst;
  logic           start_v [ND];
  logic [N*W-1:0] nums_v  [ND];
  logic           busy_v  [ND];
  logic           done_v  [ND];
  logic [OW-1:0]  sum_v   [ND];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sum_n_k_lanes #(.N(N), .W(W), .LANES(5), .SIGNED(0)) d_def (
    .clk(clk), .rst(rst), .start(start_v[0]), .nums(nums_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]));
  sum_n_k_lanes #(.N(N), .W(W), .LANES(1), .SIGNED(0)) d_l1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .nums(nums_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]));
  sum_n_k_lanes #(.N(N), .W(W), .LANES(8), .SIGNED(0)) d_l8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .nums(nums_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]));
  sum_n_k_lanes #(.N(N), .W(W), .LANES(30), .SIGNED(0)) d_l30 (
    .clk(clk), .rst(rst), .start(start_v[3]), .nums(nums_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]));
  sum_n_k_lanes #(.N(N), .W(W), .LANES(5), .SIGNED(1)) d_sgn (
    .clk(clk), .rst(rst), .start(start_v[4]), .nums(nums_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .sum(sum_v[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_sum(input logic [N*W-1:0] v, input bit sgn);
    int t = 0;
    for (int i = 0; i < N; i++) begin
      int x = int'(v[i*W +: W]);
      if (sgn && x >= (1 << (W-1))) x -= (1 << W);
      t += x;
    end
    return OW'(t);
  endfunction

  function automatic int model_lat(input int lanes);
    return (N + lanes - 1) / lanes + $clog2(lanes);
  endfunction

  function automatic logic [N*W-1:0] rand_nums();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] x);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = x;
    return r;
  endfunction

  // One full operation on instance d; nums is scrambled right after accept.
  task automatic run_op(input int d, input logic [N*W-1:0] v, input string tag);
    int  c = 0;
    bit  busy_ok = 1'b1;
    @(negedge clk);
    nums_v[d]  = v;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    nums_v[d]  = rand_nums();
    check({tag, "_busy_accept"}, busy_v[d], 1'b1);
    while (!done_v[d] && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (!done_v[d] && !busy_v[d]) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, c, model_lat(LANES_OF[d]));
    check({tag, "_sum"}, sum_v[d], model_sum(v, SGN_OF[d]));
    check({tag, "_busy_window"}, busy_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy_v[d], 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, done_v[d], 1'b0);
    check({tag, "_sum_held"}, sum_v[d], model_sum(v, SGN_OF[d]));
  endtask

  initial begin
    logic [N*W-1:0] v1, v2;
    int first, second, n_done;
    logic [OW-1:0] s1, s2;

    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      start_v[d] = 1'b0;
      nums_v[d]  = '0;
    end
    #23;
    for (int d = 0; d < ND; d++) begin
      check("rst_busy", busy_v[d], 1'b0);
      check("rst_done", done_v[d], 1'b0);
      check("rst_sum", sum_v[d], '0);
    end
    @(negedge clk);
    rst = 1'b1;

    // All-max operands, then operand capture with ramp 1..30.
    run_op(0, fill(5'd31), "def_all31");
    check("def_all31_const", sum_v[0], 10'd930);
    for (int i = 0; i < N; i++) v1[i*W +: W] = W'(i + 1);
    run_op(0, v1, "def_ramp");
    check("def_ramp_const", sum_v[0], 10'd465);

    // Signed extremes and cancelling pattern.
    run_op(4, fill(5'b10000), "sgn_min");
    check("sgn_min_const", sum_v[4], 10'h220);
    for (int i = 0; i < N; i++) v1[i*W +: W] = (i % 2 == 0) ? 5'd15 : 5'b10001;
    run_op(4, v1, "sgn_alt");

    // Busy-time starts ignored; start in the done cycle accepted.
    v1 = rand_nums();
    v2 = rand_nums();
    first = 0; second = 0; s1 = '0; s2 = '0;
    @(negedge clk);
    nums_v[0]  = v1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    nums_v[0]  = v2;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        if (first == 0) begin
          first = e; s1 = sum_v[0];
        end else if (second == 0) begin
          second = e; s2 = sum_v[0];
        end
      end
      start_v[0] = (e == 2 || e == 7 || (done_v[0] && second == 0));
    end
    start_v[0] = 1'b0;
    check("b2b_first_edge", first, 9);
    check("b2b_second_edge", second, 19);
    check("b2b_first_sum", s1, model_sum(v1, 1'b0));
    check("b2b_second_sum", s2, model_sum(v2, 1'b0));

    // Asynchronous reset mid-operation.
    @(negedge clk);
    nums_v[0]  = fill(5'd31);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy_v[0], 1'b0);
    check("mid_rst_done", done_v[0], 1'b0);
    check("mid_rst_sum", sum_v[0], '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_v[0]) n_done++;
    end
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_sum_kept", sum_v[0], '0);
    run_op(0, rand_nums(), "post_rst");

    // Lane sweep with all-max operands.
    run_op(1, fill(5'd31), "l1_all31");
    run_op(2, fill(5'd31), "l8_all31");
    run_op(3, fill(5'd31), "l30_all31");

    // Random operations on every instance.
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < ND; d++) run_op(d, rand_nums(), $sformatf("rand_d%0d", d));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
